// File: rtl/fp32_mul_seq.sv
// ---------------------------------------------------------------------------
// fp32_mul_seq -- sequential IEEE-754 single-precision multiplier.
//
// A radix-2 shift-add engine multiplies the two 24-bit significands (hidden
// bit included) one multiplier bit per cycle, LSB first. A normalise step then
// packs sign, exponent and 23 fraction bits. Denormal inputs are flushed to
// zero and no denormal results are produced. Latency is fixed: a start
// sampled at edge k raises done for one cycle after edge k+26.
//
// Build option:
//   FP32_MUL_RNE_EN  when defined, round to nearest-even using guard and
//                    sticky bits; otherwise truncate (round toward zero).
//                    Latency is identical in both builds.
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-low reset
//   start         in   1   operation request, sampled only in IDLE
//   multiplicand  in  32   operand A, captured on the accepted start edge
//   multiplier    in  32   operand B, captured on the accepted start edge
//   busy          out  1   high from the edge after acceptance through done
//   done          out  1   single-cycle completion pulse
//   product       out 32   result, held from done until the next done
// ---------------------------------------------------------------------------
module fp32_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

`ifdef FP32_MUL_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  state_t             state;
  logic [47:0]        acc;
  logic [23:0]        mcand;
  logic [23:0]        mplier;
  logic [4:0]         cnt;
  logic               sign;
  logic signed [9:0]  exp_sum;
  logic               special;
  logic [31:0]        special_val;
  logic [31:0]        result;

  // ---------------------------------------------------------------------
  // Operand decode, evaluated on the inputs so it can be captured on the
  // accepted start edge together with the significands.
  // ---------------------------------------------------------------------
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        cap_sign;
  logic        cap_special;
  logic [31:0] cap_special_val;

  assign a_exp  = multiplicand[30:23];
  assign b_exp  = multiplier[30:23];
  assign a_frac = multiplicand[22:0];
  assign b_frac = multiplier[22:0];
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  // Exponent field zero covers both true zero and denormals (flushed).
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign cap_sign = multiplicand[31] ^ multiplier[31];

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    cap_special     = 1'b0;
    cap_special_val = 32'h0000_0000;
    if (a_nan || b_nan) begin
      cap_special     = 1'b1;
      cap_special_val = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      cap_special     = 1'b1;
      cap_special_val = QNAN;
    end else if (a_inf || b_inf) begin
      cap_special     = 1'b1;
      cap_special_val = {cap_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      cap_special     = 1'b1;
      cap_special_val = {cap_sign, 31'd0};
    end
  end

  // ---------------------------------------------------------------------
  // Shift-add step: the upper half of the accumulator absorbs the partial
  // product, then the whole accumulator shifts right one place. After 24
  // steps acc holds the full 48-bit significand product.
  // ---------------------------------------------------------------------
  logic [24:0] step_sum;

  always_comb begin
    step_sum = {1'b0, acc[47:24]} + (mplier[0] ? {1'b0, mcand} : 25'd0);
  end

  // ---------------------------------------------------------------------
  // Normalise and round. The product of two [1,2) significands lies in
  // [1,4); bit 47 selects whether one extra right shift is needed.
  // ---------------------------------------------------------------------
  logic [22:0]       frac_n;
  logic              guard;
  logic              sticky;
  logic signed [9:0] exp_n;
  logic              round_up;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_r;
  logic [31:0]       norm_val;

  always_comb begin
    if (acc[47]) begin
      frac_n = acc[46:24];
      guard  = acc[23];
      sticky = |acc[22:0];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      frac_n = acc[45:23];
      guard  = acc[22];
      sticky = |acc[21:0];
      exp_n  = exp_sum;
    end

    // Nearest-even: round up above half-way, or at half-way when odd.
    round_up = RNE & guard & (sticky | frac_n[0]);
    frac_r   = {1'b0, frac_n} + {23'd0, round_up};
    // A carry out of the fraction means the significand became 2.0: the
    // fraction bits are already zero, only the exponent moves.
    exp_r    = frac_r[23] ? (exp_n + 10'sd1) : exp_n;

    if (exp_r >= 10'sd255) begin
      norm_val = {sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      norm_val = {sign, 31'd0};
    end else begin
      norm_val = {sign, exp_r[7:0], frac_r[22:0]};
    end
  end

  // ---------------------------------------------------------------------
  // Control and datapath registers.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      product     <= 32'h0000_0000;
      acc         <= 48'd0;
      cnt         <= 5'd0;
      mcand       <= 24'd0;
      mplier      <= 24'd0;
      sign        <= 1'b0;
      exp_sum     <= 10'sd0;
      special     <= 1'b0;
      special_val <= 32'h0000_0000;
      result      <= 32'h0000_0000;
    end else begin
      done <= 1'b0;
      // Registered from the current state: rises the edge after acceptance
      // and falls the edge after the done cycle.
      busy <= (state != IDLE);

      case (state)
        IDLE: begin
          if (start) begin
            mcand       <= {1'b1, a_frac};
            mplier      <= {1'b1, b_frac};
            sign        <= cap_sign;
            exp_sum     <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp})
                           - 10'sd127;
            special     <= cap_special;
            special_val <= cap_special_val;
            acc         <= 48'd0;
            cnt         <= 5'd0;
            state       <= CALC;
          end
        end

        CALC: begin
          acc    <= {step_sum, acc[23:1]};
          mplier <= {1'b0, mplier[23:1]};
          // Counter stops at 23 rather than wrapping.
          if (cnt == 5'd23) begin
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        NORM: begin
          result <= special ? special_val : norm_val;
          state  <= DONE;
        end

        DONE: begin
          product <= result;
          done    <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
